mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit. It sits between the EX/MEM pipeline register and the MEM/WB register, and drives the data-memory bus through a req/ack handshake.
- Formats load data (byte/half/word, sign/zero extend) and store byte lanes. Detects misalignment and bus timeout.
- Stalls the pipeline until each access completes. Non-memory instructions pass straight through to MEM/WB in the same cycle.

Parameters:
- ACK_TIMEOUT, 16: cycles in REQ without dmem_ack before a bus error is declared; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- MEM_Valid  in  1  EX/MEM holds a live instruction
- MEM_MemRead  in  1  load
- MEM_MemWrite  in  1  store; never high together with MEM_MemRead
- MEM_MemSize  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- MEM_LoadSigned  in  1  sign-extend byte/half loads
- MEM_AluResult  in  32  effective address, or the ALU result for non-memory ops
- MEM_StoreData  in  32  rt value for stores
- MEM_Reg_WriteAddr_In  in  5  destination register
- MEM_Reg_WriteEn_In  in  1  instruction writes a register
- MEM_Reg_WriteAddr  out  5  to MEM/WB
- MEM_Reg_WriteEn  out  1  to MEM/WB
- MEM_Reg_WriteData  out  32  to MEM/WB
- MEM_Stall  out  1  hold EX/MEM and earlier stages
- MEM_AddrErr  out  1  misaligned access, one-cycle pulse
- MEM_BusErr  out  1  ack timeout, one-cycle pulse
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] forced to 00
- dmem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- dmem_wdata  out  32  store data, lane-replicated
- dmem_ack  in  1  access complete; rdata valid in the same cycle
- dmem_rdata  in  32  read word

Behaviour:
- Byte order is little-endian: addr[1:0]=0 selects bits [7:0].
- Memory op (memop) = MEM_Valid & (MEM_MemRead | MEM_MemWrite).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, REQ, DONE. Registered items: state, the dmem_* outputs, rdata_q[31:0], err_q, cnt[7:0].
- Reset (rst=0, async): state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata = 0; rdata_q=0; err_q=0; cnt=0. MEM_AddrErr=0 and MEM_BusErr=0.
- Reset mid-access: the request is dropped immediately. No ack is awaited after release.
- IDLE, no memop: combinational pass-through.
  - Reg_WriteAddr and Reg_WriteEn come from the _In ports; WriteEn is gated by MEM_Valid.
  - WriteData = MEM_AluResult; MEM_Stall=0.
- IDLE, misaligned memop: no bus access, MEM_AddrErr=1, MEM_Reg_WriteEn=0, MEM_Stall=0. The state stays IDLE.
- IDLE, aligned memop: MEM_Stall=1 and MEM_Reg_WriteEn=0. Next state is REQ.
  - Registered at the same edge: dmem_req=1, dmem_we=MEM_MemWrite, dmem_addr={addr[31:2],2'b00}, cnt=0.
  - Store byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - Store data: byte {4{sd[7:0]}}; half {2{sd[15:0]}}; word sd. Loads use be=1111.
- REQ: MEM_Stall=1, MEM_Reg_WriteEn=0; cnt increments each cycle.
  - dmem_ack=1: dmem_req drops next edge; for loads rdata_q=formatted dmem_rdata; err_q=0; next state DONE.
  - cnt==ACK_TIMEOUT-1 with no ack: dmem_req drops; err_q=1; next state DONE.
  - Ack on the timeout cycle counts as success.
- Load formatting:
  - byte: lane addr[1:0], extended per MEM_LoadSigned.
  - half: lane addr[1], extended per MEM_LoadSigned.
  - word: dmem_rdata unchanged.
- DONE (exactly one cycle): MEM_Stall=0, so EX/MEM advances at this edge; next state IDLE.
  - MEM_BusErr=err_q.
  - Load: MEM_Reg_WriteEn = MEM_Reg_WriteEn_In & ~err_q; WriteData=rdata_q.
  - Store: WriteEn=0.
- Latency: memop seen in cycle 0, req high in cycle 1, ack no earlier than cycle 1, DONE in cycle 2. Minimum 3 cycles per access; back-to-back memops restart from IDLE.
- dmem_req is never asserted in IDLE or DONE. dmem_addr, dmem_we, dmem_be and dmem_wdata stay stable while dmem_req=1.
- Upstream holds all MEM_* inputs stable while MEM_Stall=1. The unit does not re-sample them in REQ or DONE except the _In register fields and MEM_Valid.

Test Plan:
- Non-memory op: MEM_Valid=1, WriteEn_In=1, WriteAddr_In=5'd8, AluResult=32'h1234 -> same cycle MEM_Reg_WriteEn=1, addr 8, data 32'h1234, MEM_Stall=0, dmem_req=0.
- Signed byte load: addr 32'h103, rdata 32'h80FF_0000, ack on the first REQ cycle -> be=1111, dmem_addr=32'h100. DONE writes 32'hFFFF_FF80; the unsigned variant writes 32'h0000_0080; stall lasts 2 cycles.
- Half store: addr 32'h202, sd 32'hAAAA_BEEF, ack after 3 REQ cycles -> be=1100, wdata=32'hBEEF_BEEF, we=1. MEM_Reg_WriteEn stays 0 throughout; stall lasts 4 cycles.
- Misaligned word load: addr 32'h301 -> MEM_AddrErr=1 for one cycle, dmem_req never rises, MEM_Reg_WriteEn=0, MEM_Stall=0.
- Timeout: ACK_TIMEOUT=4, load, ack never comes -> req high exactly 4 cycles, then DONE with MEM_BusErr=1 and WriteEn=0. A repeat with ack on the 4th cycle -> no error, data written.
- Reset mid-REQ: drop rst to 0 on the 2nd REQ cycle -> dmem_req=0 immediately, state IDLE. After release a pass-through op completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: formats loads/stores, drives the data-memory
// req/ack bus, stalls the pipeline until each access completes.
module mem_access_unit #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_Valid,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [1:0]  MEM_MemSize,
   input  logic        MEM_LoadSigned,
   input  logic [31:0] MEM_AluResult,
   input  logic [31:0] MEM_StoreData,
   input  logic [4:0]  MEM_Reg_WriteAddr_In,
   input  logic        MEM_Reg_WriteEn_In,
   output logic [4:0]  MEM_Reg_WriteAddr,
   output logic        MEM_Reg_WriteEn,
   output logic [31:0] MEM_Reg_WriteData,
   output logic        MEM_Stall,
   output logic        MEM_AddrErr,
   output logic        MEM_BusErr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   // state | meaning
   // IDLE  | pass-through; launches aligned memops, flags misaligned ones
   // REQ   | bus request outstanding, counting toward the ack timeout
   // DONE  | one-cycle retire of the access to MEM/WB
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        memop;
   logic        size_byte, size_half, size_word;
   logic        misalign;
   logic [3:0]  be_store;
   logic [31:0] wdata_store;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   assign memop     = MEM_Valid & (MEM_MemRead | MEM_MemWrite);
   assign size_byte = (MEM_MemSize == 2'b00);
   assign size_half = (MEM_MemSize == 2'b01);
   assign size_word = MEM_MemSize[1];
   assign misalign  = (size_half & MEM_AluResult[0]) |
                      (size_word & (|MEM_AluResult[1:0]));

   always_comb begin
      be_store    = 4'b1111;
      wdata_store = MEM_StoreData;
      if (size_byte) begin
         be_store    = 4'b0001 << MEM_AluResult[1:0];
         wdata_store = {4{MEM_StoreData[7:0]}};
      end else if (size_half) begin
         be_store    = 4'b0011 << MEM_AluResult[1:0];
         wdata_store = {2{MEM_StoreData[15:0]}};
      end
   end

   // Little-endian lane select; address/size are held stable by upstream during REQ.
   always_comb begin
      ld_byte = dmem_rdata[{MEM_AluResult[1:0], 3'b000} +: 8];
      ld_half = MEM_AluResult[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      if (size_byte)
         ld_fmt = {{24{MEM_LoadSigned & ld_byte[7]}}, ld_byte};
      else if (size_half)
         ld_fmt = {{16{MEM_LoadSigned & ld_half[15]}}, ld_half};
      else
         ld_fmt = dmem_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         cnt_q   <= 8'h0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      req_d             = req_q;
      we_d              = we_q;
      addr_d            = addr_q;
      be_d              = be_q;
      wdata_d           = wdata_q;
      rdata_d           = rdata_q;
      err_d             = err_q;
      cnt_d             = cnt_q;
      MEM_Reg_WriteAddr = MEM_Reg_WriteAddr_In;
      MEM_Reg_WriteEn   = 1'b0;
      MEM_Reg_WriteData = MEM_AluResult;
      MEM_Stall         = 1'b0;
      MEM_AddrErr       = 1'b0;
      MEM_BusErr        = 1'b0;
      case (state_q)
         IDLE: begin
            if (memop && misalign) begin
               MEM_AddrErr = 1'b1;
            end else if (memop) begin
               MEM_Stall = 1'b1;
               state_d   = REQ;
               req_d     = 1'b1;
               we_d      = MEM_MemWrite;
               addr_d    = {MEM_AluResult[31:2], 2'b00};
               be_d      = MEM_MemWrite ? be_store : 4'b1111;
               wdata_d   = MEM_MemWrite ? wdata_store : 32'h0;
               cnt_d     = 8'h0;
            end else begin
               MEM_Reg_WriteEn = MEM_Valid & MEM_Reg_WriteEn_In;
            end
         end
         REQ: begin
            MEM_Stall = 1'b1;
            cnt_d     = cnt_q + 8'd1;
            // An ack on the final timeout cycle still wins.
            if (dmem_ack) begin
               req_d   = 1'b0;
               err_d   = 1'b0;
               state_d = DONE;
               if (!we_q)
                  rdata_d = ld_fmt;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            MEM_BusErr = err_q;
            state_d    = IDLE;
            if (!we_q) begin
               MEM_Reg_WriteEn   = MEM_Reg_WriteEn_In & ~err_q;
               MEM_Reg_WriteData = rdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule
